bist_sequencer: RTL and testbench

- Sequences one BIST session around the 8-bit PRPG blocks (LFSR / CFSR / BSLFSR variants).
- Sequence: seeds the selected PRPG, steps it for a programmed number of patterns, and feeds CUT responses into the MISR. It then compares the final MISR signature against a golden value and reports pass/fail.
- Sits between the top-level test control and the PRPG, CUT input mux and MISR.

---
 rtl/bist_pkg.sv | 31 +++
 rtl/bist_pat_counter.sv | 37 +++
 rtl/bist_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_bist_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST session sequencer: state encoding,
// PRPG variant select codes and default datapath widths.
package bist_pkg;

    localparam int unsigned DEF_PAT_W = 8;
    localparam int unsigned DEF_SIG_W = 8;
    localparam int unsigned DEF_CNT_W = 9;

    localparam logic [1:0] SEL_LFSR   = 2'd0;
    localparam logic [1:0] SEL_CFSR   = 2'd1;
    localparam logic [1:0] SEL_BSLFSR = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Reserved select code falls back to the plain LFSR.
    function automatic logic [1:0] map_sel(input logic [1:0] sel);
        case (sel)
            SEL_CFSR:   return SEL_CFSR;
            SEL_BSLFSR: return SEL_BSLFSR;
            default:    return SEL_LFSR;
        endcase
    endfunction

endpackage

// File: rtl/bist_pat_counter.sv
// Pattern counter for one BIST session.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         synchronous clear to zero (wins over en)
//   en          increment by one
//   limit       pattern count of the session (always >= 1 when used)
//   count       patterns applied so far
//   last_c      count == limit-1, i.e. the current cycle applies the final pattern
module bist_pat_counter
    import bist_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             last_c
);

    // Up-counter with clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal-count flag.
    assign last_c = (count == (limit - CNT_W'(1)));

endmodule

// File: rtl/bist_sequencer.sv
// Sequences one BIST session: seed the PRPG, step it for the programmed
// number of patterns, compact CUT responses in the MISR (delayed by the CUT
// latency), then compare the signature against the golden value.
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   start, abort        session request / cancel
//   prpg_sel_in, seed_in, num_pat, golden_sig   session setup, captured on start
//   misr_sig            current MISR signature
//   prpg_sel, prpg_seed, prpg_load, prpg_en     PRPG control
//   test_mode           CUT input mux select (PRPG side)
//   misr_clr, misr_en   MISR control
//   pat_cnt             patterns applied so far
//   busy, done, pass    session status
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int unsigned PAT_W   = DEF_PAT_W,
    parameter int unsigned SIG_W   = DEF_SIG_W,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned CUT_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       prpg_sel_in,
    input  logic [PAT_W-1:0] seed_in,
    input  logic [CNT_W-1:0] num_pat,
    input  logic [SIG_W-1:0] golden_sig,
    input  logic [SIG_W-1:0] misr_sig,
    output logic [1:0]       prpg_sel,
    output logic [PAT_W-1:0] prpg_seed,
    output logic             prpg_load,
    output logic             prpg_en,
    output logic             test_mode,
    output logic             misr_clr,
    output logic             misr_en,
    output logic [CNT_W-1:0] pat_cnt,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int unsigned LAT_W      = 3;
    localparam int unsigned FLUSH_LAST = (CUT_LAT > 0) ? CUT_LAT - 1 : 0;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   limit_q;
    logic [SIG_W-1:0]   golden_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LAT_W-1:0]   flush_cnt;
    logic               lat_full_c;
    logic               accept_c;
    logic               cnt_clr_c;
    logic               cnt_en_c;
    logic               cnt_last_c;

    // Counts cycles since RUN entry, saturating at CUT_LAT: the first CUT
    // response reaches the MISR CUT_LAT cycles after the first pattern.
    assign lat_full_c = (lat_cnt == LAT_W'(CUT_LAT));

    bist_pat_counter #(
        .CNT_W (CNT_W)
    ) u_pat_counter (
        .clk    (clk),
        .rst_n  (reset),
        .clr    (cnt_clr_c),
        .en     (cnt_en_c),
        .limit  (limit_q),
        .count  (pat_cnt),
        .last_c (cnt_last_c)
    );

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        prpg_load  = 1'b0;
        prpg_en    = 1'b0;
        test_mode  = 1'b0;
        misr_clr   = 1'b0;
        misr_en    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cnt_clr_c  = 1'b0;
        cnt_en_c   = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (start) begin
                    if (abort) begin
                        state_next = ST_IDLE;
                    end else begin
                        accept_c   = 1'b1;
                        state_next = ST_INIT;
                    end
                end
            end
            ST_INIT: begin
                prpg_load  = 1'b1;
                misr_clr   = 1'b1;
                test_mode  = 1'b1;
                busy       = 1'b1;
                cnt_clr_c  = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                prpg_en   = 1'b1;
                test_mode = 1'b1;
                busy      = 1'b1;
                cnt_en_c  = 1'b1;
                misr_en   = lat_full_c;
                if (cnt_last_c) begin
                    state_next = (CUT_LAT > 0) ? ST_FLUSH : ST_COMPARE;
                end
            end
            ST_FLUSH: begin
                test_mode = 1'b1;
                busy      = 1'b1;
                misr_en   = lat_full_c;
                if (flush_cnt == LAT_W'(FLUSH_LAST)) begin
                    state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort overrides every transition of an active session.
        if (abort && busy) begin
            state_next = ST_IDLE;
        end
    end

    // State, captured setup, verdict and latency/flush counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            prpg_sel  <= '0;
            prpg_seed <= '0;
            limit_q   <= '0;
            golden_q  <= '0;
            pass      <= 1'b0;
            lat_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_next;

            if (accept_c) begin
                prpg_sel  <= map_sel(prpg_sel_in);
                prpg_seed <= seed_in;
                limit_q   <= (num_pat == '0) ? CNT_W'(1) : num_pat;
                golden_q  <= golden_sig;
            end

            if (accept_c || state_next == ST_IDLE) begin
                pass <= 1'b0;
            end else if (state == ST_COMPARE) begin
                pass <= (misr_sig == golden_q);
            end

            if (state == ST_INIT) begin
                lat_cnt <= '0;
            end else if ((state == ST_RUN || state == ST_FLUSH) && !lat_full_c) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end

            if (state == ST_FLUSH) begin
                flush_cnt <= flush_cnt + LAT_W'(1);
            end else begin
                flush_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer. A behavioural PRPG/CUT/MISR
// environment feeds misr_sig; expected signatures, pattern counts and
// latencies come from a plain loop over the session rules.
module tb_bist_sequencer;

    localparam int unsigned TB_LAT = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [1:0] prpg_sel_in;
    logic [7:0] seed_in;
    logic [8:0] num_pat;
    logic [7:0] golden_sig;
    logic [7:0] misr_sig;
    logic [1:0] prpg_sel;
    logic [7:0] prpg_seed;
    logic       prpg_load;
    logic       prpg_en;
    logic       test_mode;
    logic       misr_clr;
    logic       misr_en;
    logic [8:0] pat_cnt;
    logic       busy;
    logic       done;
    logic       pass;

    int total = 0;
    int bad   = 0;

    bist_sequencer #(
        .PAT_W   (8),
        .SIG_W   (8),
        .CNT_W   (9),
        .CUT_LAT (TB_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .prpg_sel_in (prpg_sel_in),
        .seed_in     (seed_in),
        .num_pat     (num_pat),
        .golden_sig  (golden_sig),
        .misr_sig    (misr_sig),
        .prpg_sel    (prpg_sel),
        .prpg_seed   (prpg_seed),
        .prpg_load   (prpg_load),
        .prpg_en     (prpg_en),
        .test_mode   (test_mode),
        .misr_clr    (misr_clr),
        .misr_en     (misr_en),
        .pat_cnt     (pat_cnt),
        .busy        (busy),
        .done        (done),
        .pass        (pass)
    );

    always #5 clk = ~clk;

    // Environment functions: PRPG variants, CUT transform, MISR step.
    function automatic logic [7:0] prpg_step(input logic [1:0] sel, input logic [7:0] p);
        case (sel)
            2'd1:    return {p[6:0], p[7] ^ p[6] ^ p[1] ^ p[0]};
            2'd2:    return {1'b0, p[7:1]} ^ (p[0] ? 8'hB8 : 8'h00);
            default: return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
        endcase
    endfunction

    function automatic logic [7:0] cut_f(input logic [7:0] x);
        logic [7:0] t;
        t = x * 8'd5;
        return t ^ 8'h3C;
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], s[7] ^ s[3] ^ s[2] ^ s[1]} ^ d;
    endfunction

    // Reference signature: n patterns from the seed, each transformed by the CUT.
    function automatic logic [7:0] ref_sig(input logic [1:0] sel, input logic [7:0] seed, input int n);
        logic [1:0] s_eff;
        logic [7:0] p;
        logic [7:0] s;
        s_eff = (sel == 2'd3) ? 2'd0 : sel;
        p = seed;
        s = 8'h00;
        for (int k = 0; k < n; k++) begin
            s = misr_step(s, cut_f(p));
            p = prpg_step(s_eff, p);
        end
        return s;
    endfunction

    // Cycle-level PRPG / CUT pipeline / MISR environment.
    logic [7:0] env_pat;
    logic [7:0] env_cut;
    logic [7:0] env_sig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            env_pat <= 8'h00;
            env_cut <= 8'h00;
            env_sig <= 8'h00;
        end else begin
            if (prpg_load) begin
                env_pat <= prpg_seed;
            end else if (prpg_en) begin
                env_pat <= prpg_step(prpg_sel, env_pat);
            end
            env_cut <= cut_f(test_mode ? env_pat : 8'h00);
            if (misr_clr) begin
                env_sig <= 8'h00;
            end else if (misr_en) begin
                env_sig <= misr_step(env_sig, env_cut);
            end
        end
    end

    assign misr_sig = env_sig;

    // Running activity counts, sampled away from the active edge.
    int n_load = 0;
    int n_en   = 0;
    int n_misr = 0;
    int n_ov   = 0;

    always @(negedge clk) begin
        if (prpg_load) n_load++;
        if (prpg_en) n_en++;
        if (misr_en) n_misr++;
        if (prpg_load && prpg_en) n_ov++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full session; mid_start > 0 pulses start at that cycle of the session.
    task automatic run_session(input logic [1:0] sel, input logic [7:0] seed, input logic [8:0] np,
                               input logic [7:0] gold, input int mid_start);
        int         n;
        int         cycles;
        int         b_load;
        int         b_en;
        int         b_misr;
        int         b_ov;
        logic [7:0] exp_sig;
        logic [1:0] exp_sel;
        n       = (np == 9'd0) ? 1 : int'(np);
        exp_sig = ref_sig(sel, seed, n);
        exp_sel = (sel == 2'd3) ? 2'd0 : sel;
        @(negedge clk);
        b_load = n_load;
        b_en   = n_en;
        b_misr = n_misr;
        b_ov   = n_ov;
        prpg_sel_in = sel;
        seed_in     = seed;
        num_pat     = np;
        golden_sig  = gold;
        start       = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        check("init_busy", 32'(busy), 32'd1);
        check("init_done_clr", 32'(done), 32'd0);
        while (!done && cycles < 700) begin
            if (mid_start > 0 && cycles == mid_start) begin
                start   = 1'b1;
                seed_in = ~seed;
                num_pat = 9'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("done", 32'(done), 32'd1);
        check("latency", 32'(cycles - 1), 32'(n + int'(TB_LAT) + 2));
        check("load_cnt", 32'(n_load - b_load), 32'd1);
        check("en_cnt", 32'(n_en - b_en), 32'(n));
        check("misr_en_cnt", 32'(n_misr - b_misr), 32'(n));
        check("load_en_overlap", 32'(n_ov - b_ov), 32'd0);
        check("pat_cnt", 32'(pat_cnt), 32'(n));
        check("signature", 32'(misr_sig), 32'(exp_sig));
        check("pass", 32'(pass), 32'(gold == exp_sig));
        check("done_busy", 32'(busy), 32'd0);
        check("done_test_mode", 32'(test_mode), 32'd0);
        check("sel", 32'(prpg_sel), 32'(exp_sel));
        check("seed", 32'(prpg_seed), 32'(seed));
    endtask

    initial begin
        logic [1:0] r_sel;
        logic [7:0] r_seed;
        logic [8:0] r_np;
        logic [7:0] r_gold;
        int         r_n;

        reset       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        prpg_sel_in = 2'd0;
        seed_in     = 8'h00;
        num_pat     = 9'd0;
        golden_sig  = 8'h00;

        #12;
        check("reset_outs",
              32'({prpg_sel, prpg_seed, pat_cnt, busy, done, pass, prpg_load, prpg_en,
                   test_mode, misr_clr, misr_en}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_quiet", 32'({busy, done, test_mode, prpg_en}), 32'd0);

        // Directed: matching golden, then a wrong golden.
        run_session(2'd1, 8'h01, 9'd255, ref_sig(2'd1, 8'h01, 255), 0);
        run_session(2'd1, 8'h01, 9'd255, 8'hA5, 0);

        // Pattern-count boundaries.
        run_session(2'd0, 8'h77, 9'd0, 8'h00, 0);
        run_session(2'd2, 8'hC3, 9'd256, ref_sig(2'd2, 8'hC3, 256), 0);

        // start during RUN is ignored.
        run_session(2'd3, 8'h9E, 9'd30, ref_sig(2'd3, 8'h9E, 30), 6);

        // abort alone in DONE does nothing.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_done", 32'({done, busy}), 32'b10);

        // start together with abort in DONE returns to IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_done", 32'({done, busy, pass}), 32'd0);
        @(negedge clk);
        check("start_abort_idle", 32'({done, busy, prpg_load}), 32'd0);

        // Abort at RUN cycle 10.
        prpg_sel_in = 2'd0;
        seed_in     = 8'h33;
        num_pat     = 9'd40;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("run10_active", 32'({prpg_en, busy}), 32'b11);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outs", 32'({busy, done, prpg_en, pass, test_mode}), 32'd0);
        run_session(2'd2, 8'h5A, 9'd20, ref_sig(2'd2, 8'h5A, 20), 0);

        // Randomized sessions, each started from DONE.
        for (int i = 0; i < 6; i++) begin
            r_sel  = 2'($urandom_range(0, 3));
            r_seed = 8'($urandom);
            r_np   = (i < 2) ? 9'($urandom_range(0, 2)) : 9'($urandom_range(3, 60));
            r_n    = (r_np == 9'd0) ? 1 : int'(r_np);
            r_gold = ($urandom_range(0, 1) == 1) ? ref_sig(r_sel, r_seed, r_n) : 8'($urandom);
            run_session(r_sel, r_seed, r_np, r_gold, (i == 3) ? 5 : 0);
        end

        // Asynchronous reset during FLUSH.
        @(negedge clk);
        prpg_sel_in = 2'd1;
        seed_in     = 8'hE1;
        num_pat     = 9'd4;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("in_flush", 32'({busy, prpg_en, misr_en}), 32'b101);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outs",
              32'({prpg_sel, prpg_seed, pat_cnt, busy, done, pass, prpg_load, prpg_en,
                   test_mode, misr_clr, misr_en}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_quiet",
                  32'({busy, done, test_mode, prpg_en, prpg_load, misr_en, misr_clr}), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
